uart_mult_byte_tx: RTL and testbench
====================================

Name: uart_mult_byte_tx

Overview:
Multi-byte UART packet transmitter. It is the transmit-side counterpart of the multi-byte packet receiver. It frames a fixed-length payload as header, length, payload and CRC8, then serialises it 8N1 on uart_txd. It sits in the 50 MHz domain and feeds the board UART TX pin, for status reports and register read-back to the host.

Parameters:
- CLK_FREQ, 50_000_000, input clock frequency in Hz.
- BAUD, 115200, line rate. Bit period BIT_CYC = CLK_FREQ/BAUD with integer truncation (434 at defaults).
- PAY_LEN, 11, payload bytes per packet. Legal range 1..32.
- HDR0, 8'h55, first header byte.
- HDR1, 8'hAA, second header byte.

Ports:
- clk_50M_o  in  1  system clock, 50 MHz.
- rst_n  in  1  reset, asynchronous, active-low.
- send_req  in  1  single-cycle request to transmit one packet.
- payload  in  8*PAY_LEN  payload; byte k is payload[8k+7:8k], byte 0 is sent first.
- busy  out  1  high while a packet is in flight.
- tx_done  out  1  one-cycle pulse when the packet's final stop bit ends.
- uart_txd  out  1  serial line, idle high.

Behaviour:
- Reset values: uart_txd=1, busy=0, tx_done=0. All counters are 0 and the FSM is in IDLE.
- Reset asserted mid-packet: uart_txd returns to 1 asynchronously. The packet is discarded and there is no tx_done.
- Frame order: HDR0, HDR1, LEN, payload byte 0..PAY_LEN-1, CRC. Total PAY_LEN+4 bytes.
  - LEN = PAY_LEN[7:0].
- CRC: CRC-8, poly 0x07, init 0x00, no reflection, no final XOR, MSB-first. It covers the payload bytes only.
  - Computed byte-serially as each payload byte is loaded for transmission (8-bit combinational step per byte).
  - Must be final before the CRC byte loads.
- Byte format: start bit 0, 8 data bits LSB first, stop bit 1. Each bit is held exactly BIT_CYC cycles.
  - No idle gap between bytes: the next start bit immediately follows the previous stop bit.
- Packet FSM states: IDLE, SEND_BYTE, NEXT, DONE.
  - IDLE → SEND_BYTE when send_req=1. On acceptance, payload is latched into an internal shadow register and the CRC is cleared.
  - SEND_BYTE: the byte engine is busy. When it finishes → NEXT.
  - NEXT: if the byte index equals PAY_LEN+3 → DONE. Otherwise increment the index, load the next byte, → SEND_BYTE.
  - DONE: pulse tx_done for one cycle → IDLE.
  - NEXT is a zero-length decision state (merged combinationally with the load). The inter-byte spacing is therefore exactly 10*BIT_CYC.
- Timing:
  - send_req sampled high at edge N: busy=1 and uart_txd=0 (HDR0 start bit) from edge N+1.
  - Last stop bit ends at edge N+1+(PAY_LEN+4)*10*BIT_CYC. At that edge tx_done=1 and busy=0.
- send_req while busy=1 is ignored, with no queuing.
- send_req in the same cycle tx_done pulses is ignored. A new request is accepted from the following cycle.
- Changes to payload after acceptance do not affect the packet in flight.

Decomposition:
- Package uart_tx_pkg holds:
  - CRC8_POLY=8'h07.
  - Default HDR0/HDR1.
  - Function crc8_step(crc, byte), shared with the receiver for CRC checking.
- Sub-module uart_byte_tx holds the bit engine:
  - Ports: clk_50M_o, rst_n, start, data[7:0], busy, done, txd.
  - Contents: baud counter 0..BIT_CYC-1 and bit index 0..9.
  - Same start-to-start latency rule as above.
- The top level holds the packet FSM, the shadow register, the byte mux and the CRC register.

Test Plan:
1. Reset idle: hold rst_n=0 for 10 cycles, then release and run 1000 cycles. Required: uart_txd=1, busy=0, tx_done=0 throughout.
2. Default packet: payload all 0x00, pulse send_req. Bench UART decoder sampling at mid-bit (434 cycles/bit) must read 55 AA 0B 00×11 00. Required:
   - busy rises 1 cycle after the request.
   - tx_done arrives exactly 1+15*4340 = 65101 cycles after the sampled request.
3. CRC vector: PAY_LEN=9 override, payload ASCII "123456789". Required: decoded frame 55 AA 09 31..39 F4.
4. Bit timing: payload byte0 = 0xA5. Required:
   - Every uart_txd edge lands on a multiple of 434 cycles from the start bit.
   - Byte0 data bits read 1,0,1,0,0,1,0,1 (LSB first).
5. Request while busy: re-pulse send_req at cycle 2000 of a packet and change payload to 0xFF. Required: exactly one packet emitted, with the original data, and one tx_done pulse.
6. Reset mid-packet: deassert rst_n in the middle of the payload bytes, then release and pulse send_req. Required:
   - uart_txd goes high immediately on reset and no tx_done is produced.
   - The next packet is complete and correct.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared UART packet constants, FSM state type and CRC-8 step
//
// Purpose : constants and helpers common to the packet transmitter and the
//           matching packet receiver.
// Contents: CRC8_POLY, default header bytes, packet FSM state type,
//           crc8_step() byte-wise CRC-8 update (poly 0x07, MSB first).
package uart_tx_pkg;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] DEF_HDR0  = 8'h55;
  localparam logic [7:0] DEF_HDR1  = 8'hAA;

  // ST_NEXT is the zero-length decision point between bytes; it is folded
  // into the SEND_BYTE exit so it never appears as a registered state.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND_BYTE = 2'd1,
    ST_NEXT      = 2'd2,
    ST_DONE      = 2'd3
  } pkt_state_e;

  // One full byte of CRC-8 (no reflection, no final XOR), MSB first.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc,
                                           input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// rtl/uart_byte_tx.sv - 8N1 single-byte serialiser
//
// Purpose : shifts one byte out as start(0), 8 data bits LSB first, stop(1),
//           each bit held BIT_CYC clocks. A start presented during the last
//           cycle of the stop bit chains the next byte with no idle gap.
// Ports   : clk_50M_o  clock
//           rst_n      async active-low reset (txd forced high)
//           start      load data and begin a byte (accepted when idle or on done)
//           data[7:0]  byte to send, captured on start
//           busy       byte in flight
//           done       high during the final cycle of the stop bit
//           txd        serial output, idle high
module uart_byte_tx #(
  parameter int BIT_CYC = 434
) (
  input  logic       clk_50M_o,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic       txd
);

  localparam int CW = $clog2(BIT_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;   // 0 start, 1..8 data, 9 stop
  logic [7:0]    sh_q, sh_d;
  logic          busy_q, busy_d;
  logic          txd_q, txd_d;
  logic          bit_end;
  logic          last;

  assign bit_end = (cnt_q == CNT_LAST);
  assign last    = busy_q && bit_end && (bit_q == 4'd9);

  always_comb begin
    cnt_d  = cnt_q;
    bit_d  = bit_q;
    sh_d   = sh_q;
    busy_d = busy_q;
    txd_d  = txd_q;
    if (start && (!busy_q || last)) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      bit_d  = 4'd0;
      sh_d   = data;
      txd_d  = 1'b0;
    end else if (busy_q) begin
      if (bit_end) begin
        cnt_d = '0;
        if (bit_q == 4'd9) begin
          busy_d = 1'b0;
          txd_d  = 1'b1;
        end else begin
          bit_d = bit_q + 4'd1;
          // Leaving bit n enters bit n+1: data bit n for n=0..7, stop after 8.
          txd_d = (bit_q == 4'd8) ? 1'b1 : sh_q[bit_q[2:0]];
        end
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_50M_o or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      bit_q  <= 4'd0;
      sh_q   <= 8'h00;
      busy_q <= 1'b0;
      txd_q  <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      bit_q  <= bit_d;
      sh_q   <= sh_d;
      busy_q <= busy_d;
      txd_q  <= txd_d;
    end
  end

  assign busy = busy_q;
  assign done = last;
  assign txd  = txd_q;

endmodule

// File: rtl/uart_mult_byte_tx.sv
// rtl/uart_mult_byte_tx.sv - multi-byte UART packet transmitter (hdr, len, payload, CRC-8)
//
// Purpose : frames PAY_LEN payload bytes as HDR0 HDR1 LEN payload[0..] CRC8
//           and sends them back-to-back 8N1 on uart_txd.
// Ports   : clk_50M_o  50 MHz clock
//           rst_n      async active-low reset
//           send_req   one-cycle packet request (ignored while busy/tx_done)
//           payload    8*PAY_LEN bits, byte k at [8k+7:8k], byte 0 sent first
//           busy       packet in flight
//           tx_done    one-cycle pulse as the final stop bit ends
//           uart_txd   serial line, idle high
module uart_mult_byte_tx
  import uart_tx_pkg::*;
#(
  parameter int         CLK_FREQ = 50_000_000,
  parameter int         BAUD     = 115200,
  parameter int         PAY_LEN  = 11,
  parameter logic [7:0] HDR0     = DEF_HDR0,
  parameter logic [7:0] HDR1     = DEF_HDR1
) (
  input  logic                   clk_50M_o,
  input  logic                   rst_n,
  input  logic                   send_req,
  input  logic [8*PAY_LEN-1:0]   payload,
  output logic                   busy,
  output logic                   tx_done,
  output logic                   uart_txd
);

  localparam int         BIT_CYC  = CLK_FREQ / BAUD;
  localparam logic [5:0] LAST_IDX = 6'(PAY_LEN + 3);
  localparam logic [7:0] LEN_BYTE = 8'(PAY_LEN);

  pkt_state_e           state_q, state_d;
  logic [5:0]           idx_q, idx_d;
  logic [8*PAY_LEN-1:0] shadow_q, shadow_d;
  logic [7:0]           crc_q, crc_d;
  logic                 req_q, req_d;
  logic                 busy_q, busy_d;
  logic                 tx_done_q, tx_done_d;

  logic [5:0] nxt_idx;
  logic [7:0] nxt_byte;
  logic [7:0] pay_byte;
  logic       is_pay;
  logic       eng_start;
  logic       eng_busy;
  logic       eng_done;

  // Byte that would be loaded next: index 0 from IDLE, otherwise idx+1.
  always_comb begin
    nxt_idx  = (state_q == ST_IDLE) ? 6'd0 : idx_q + 6'd1;
    pay_byte = 8'h00;
    is_pay   = 1'b0;
    for (int k = 0; k < PAY_LEN; k++) begin
      if (nxt_idx == 6'(k + 3)) begin
        pay_byte = shadow_q[8*k +: 8];
        is_pay   = 1'b1;
      end
    end
    if (nxt_idx == 6'd0)          nxt_byte = HDR0;
    else if (nxt_idx == 6'd1)     nxt_byte = HDR1;
    else if (nxt_idx == 6'd2)     nxt_byte = LEN_BYTE;
    else if (nxt_idx == LAST_IDX) nxt_byte = crc_q;
    else                          nxt_byte = pay_byte;
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    crc_d     = crc_q;
    busy_d    = busy_q;
    tx_done_d = 1'b0;
    eng_start = 1'b0;
    // A request is captured only from a truly idle FSM, which also makes
    // a request during the tx_done cycle (state DONE) fall on the floor.
    req_d     = send_req && (state_q == ST_IDLE) && !req_q;
    if (req_d) begin
      shadow_d = payload;
      crc_d    = 8'h00;
    end
    case (state_q)
      ST_IDLE: begin
        if (req_q && !eng_busy) begin
          eng_start = 1'b1;
          idx_d     = 6'd0;
          busy_d    = 1'b1;
          state_d   = ST_SEND_BYTE;
        end
      end
      ST_SEND_BYTE: begin
        // Decision (NEXT) happens in the stop bit's last cycle so the next
        // start bit follows with no gap.
        if (eng_done) begin
          if (idx_q == LAST_IDX) begin
            busy_d    = 1'b0;
            tx_done_d = 1'b1;
            state_d   = ST_DONE;
          end else begin
            idx_d     = nxt_idx;
            eng_start = 1'b1;
            if (is_pay) crc_d = crc8_step(crc_q, nxt_byte);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_50M_o or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= 6'd0;
      shadow_q  <= '0;
      crc_q     <= 8'h00;
      req_q     <= 1'b0;
      busy_q    <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      crc_q     <= crc_d;
      req_q     <= req_d;
      busy_q    <= busy_d;
      tx_done_q <= tx_done_d;
    end
  end

  uart_byte_tx #(
    .BIT_CYC (BIT_CYC)
  ) u_byte_tx (
    .clk_50M_o (clk_50M_o),
    .rst_n     (rst_n),
    .start     (eng_start),
    .data      (nxt_byte),
    .busy      (eng_busy),
    .done      (eng_done),
    .txd       (uart_txd)
  );

  assign busy    = busy_q;
  assign tx_done = tx_done_q;

endmodule

// File: tb/tb_uart_mult_byte_tx.sv
// tb/tb_uart_mult_byte_tx.sv - self-checking bench for uart_mult_byte_tx
module tb_uart_mult_byte_tx;

  localparam int B     = 16;                 // 50 MHz / 3.125 MBd
  localparam int PL0   = 11;
  localparam int PL1   = 9;
  localparam int TOT0  = (PL0 + 4) * 10 * B;
  localparam int TOT1  = (PL1 + 4) * 10 * B;

  logic clk_50M_o;
  logic rst_n;
  logic [1:0] req, busy, done, txd;
  logic [8*PL0-1:0] pay_a;
  logic [8*PL1-1:0] pay_b;
  logic [7:0] pb [2][32];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int ndone0  = 0;
  int ndone1  = 0;

  bit         act [2];
  int         age [2];
  logic [7:0] fr  [2][36];
  logic [7:0] rxq0 [$];
  logic [7:0] rxq1 [$];

  uart_mult_byte_tx #(.CLK_FREQ(50_000_000), .BAUD(3_125_000), .PAY_LEN(PL0)) dut_a (
    .clk_50M_o (clk_50M_o), .rst_n (rst_n), .send_req (req[0]), .payload (pay_a),
    .busy (busy[0]), .tx_done (done[0]), .uart_txd (txd[0]));

  uart_mult_byte_tx #(.CLK_FREQ(50_000_000), .BAUD(3_125_000), .PAY_LEN(PL1)) dut_b (
    .clk_50M_o (clk_50M_o), .rst_n (rst_n), .send_req (req[1]), .payload (pay_b),
    .busy (busy[1]), .tx_done (done[1]), .uart_txd (txd[1]));

  initial clk_50M_o = 1'b0;
  always #10 clk_50M_o = ~clk_50M_o;

  always_comb begin
    for (int k = 0; k < PL0; k++) pay_a[8*k +: 8] = pb[0][k];
    for (int k = 0; k < PL1; k++) pay_b[8*k +: 8] = pb[1][k];
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", nm, cyc, got, want);
    end
  endtask

  // CRC-8 as polynomial remainder of the augmented message mod x^8+x^2+x+1.
  function automatic logic [7:0] crc_ref(input int i, input int n);
    logic [8:0] r;
    r = 9'h000;
    for (int k = 0; k < n + 1; k++) begin
      for (int b = 7; b >= 0; b--) begin
        r = {r[7:0], (k < n) ? pb[i][k][b] : 1'b0};
        if (r[8]) r = r ^ 9'h107;
      end
    end
    return r[7:0];
  endfunction

  function automatic int plen(input int i);
    return (i == 0) ? PL0 : PL1;
  endfunction

  function automatic int tot(input int i);
    return (i == 0) ? TOT0 : TOT1;
  endfunction

  // Packet-level model: age counts clock edges since the request was sampled.
  always @(posedge clk_50M_o or negedge rst_n) begin
    if (!rst_n) begin
      act[0] = 1'b0;
      act[1] = 1'b0;
    end else begin
      cyc++;
      for (int i = 0; i < 2; i++) begin
        if (act[i]) begin
          if (age[i] == tot(i) + 1) act[i] = 1'b0;
          else age[i]++;
        end else if (req[i]) begin
          act[i] = 1'b1;
          age[i] = 0;
          fr[i][0] = 8'h55;
          fr[i][1] = 8'hAA;
          fr[i][2] = 8'(plen(i));
          for (int k = 0; k < plen(i); k++) fr[i][3+k] = pb[i][k];
          fr[i][plen(i)+3] = crc_ref(i, plen(i));
        end
      end
    end
  end

  always @(negedge clk_50M_o) begin
    for (int i = 0; i < 2; i++) begin
      logic et, eb, ed;
      int o, bi, bt;
      et = 1'b1; eb = 1'b0; ed = 1'b0;
      if (rst_n && act[i] && age[i] >= 1) begin
        if (age[i] <= tot(i)) begin
          eb = 1'b1;
          o  = age[i] - 1;
          bi = o / (10 * B);
          bt = (o % (10 * B)) / B;
          if (bt == 0)      et = 1'b0;
          else if (bt == 9) et = 1'b1;
          else              et = fr[i][bi][bt-1];
        end else begin
          ed = 1'b1;
        end
      end
      chk($sformatf("txd%0d", i), {31'd0, txd[i]}, {31'd0, et});
      chk($sformatf("busy%0d", i), {31'd0, busy[i]}, {31'd0, eb});
      chk($sformatf("tx_done%0d", i), {31'd0, done[i]}, {31'd0, ed});
    end
    if (done[0] === 1'b1) ndone0++;
    if (done[1] === 1'b1) ndone1++;
  end

  // Line decoder: samples each bit near its middle.
  task automatic decode(input int i);
    logic [7:0] v;
    forever begin
      @(negedge clk_50M_o);
      if (rst_n && txd[i] === 1'b0) begin
        repeat (B/2) @(negedge clk_50M_o);
        v = 8'h00;
        for (int b = 0; b < 8; b++) begin
          repeat (B) @(negedge clk_50M_o);
          v[b] = txd[i];
        end
        repeat (B) @(negedge clk_50M_o);
        if (i == 0) rxq0.push_back(v);
        else        rxq1.push_back(v);
      end
    end
  endtask

  initial decode(0);
  initial decode(1);

  function automatic logic [7:0] rxb(input int i, input int k);
    if (i == 0) return (k < rxq0.size()) ? rxq0[k] : 8'hxx;
    return (k < rxq1.size()) ? rxq1[k] : 8'hxx;
  endfunction

  function automatic int rxn(input int i);
    return (i == 0) ? rxq0.size() : rxq1.size();
  endfunction

  task automatic run_packet(input int i, output int lat);
    rxq0.delete();
    rxq1.delete();
    @(negedge clk_50M_o); req[i] = 1'b1;
    @(negedge clk_50M_o); req[i] = 1'b0;
    chk("busy_before", {31'd0, busy[i]}, 32'd0);
    lat = 0;
    while (lat < 5000) begin
      @(negedge clk_50M_o);
      lat++;
      if (lat == 1) chk("busy_rise", {31'd0, busy[i]}, 32'd1);
      if (done[i] === 1'b1) break;
    end
    repeat (4) @(negedge clk_50M_o);
  endtask

  task automatic chk_frame_model(input int i, input string nm);
    chk({nm, "_len"}, rxn(i), plen(i) + 4);
    for (int k = 0; k < plen(i) + 4; k++)
      chk($sformatf("%s_b%0d", nm, k), {24'd0, rxb(i, k)}, {24'd0, fr[i][k]});
  endtask

  logic [7:0] crcv [13];
  logic [7:0] a5b;
  int lat;

  initial begin
    crcv = '{8'h55, 8'hAA, 8'h09, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
             8'h36, 8'h37, 8'h38, 8'h39, 8'hF4};
    req   = 2'b00;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) for (int k = 0; k < 32; k++) pb[i][k] = 8'h00;

    // 1: reset and idle
    repeat (10) @(negedge clk_50M_o);
    rst_n = 1'b1;
    repeat (1000) @(negedge clk_50M_o);
    chk("idle_txd", {30'd0, txd}, 32'd3);
    chk("idle_busy", {30'd0, busy}, 32'd0);
    chk("idle_done_cnt", ndone0 + ndone1, 0);

    // 2: all-zero default-length packet
    run_packet(0, lat);
    chk("zero_latency", lat, 1 + 15 * 10 * B);
    chk("zero_len", rxn(0), 15);
    chk("zero_h0", {24'd0, rxb(0, 0)}, 32'h55);
    chk("zero_h1", {24'd0, rxb(0, 1)}, 32'hAA);
    chk("zero_lenb", {24'd0, rxb(0, 2)}, 32'h0B);
    for (int k = 3; k < 15; k++) chk($sformatf("zero_b%0d", k), {24'd0, rxb(0, k)}, 32'h00);

    // 3: CRC check vector on the 9-byte instance
    for (int k = 0; k < 9; k++) pb[1][k] = 8'(8'h31 + k);
    run_packet(1, lat);
    chk("crc_latency", lat, 1 + 13 * 10 * B);
    chk("crc_len", rxn(1), 13);
    for (int k = 0; k < 13; k++) chk($sformatf("crc_b%0d", k), {24'd0, rxb(1, k)}, {24'd0, crcv[k]});

    // 4: bit order / timing with 0xA5 leading the payload
    pb[0][0] = 8'hA5;
    for (int k = 1; k < PL0; k++) pb[0][k] = 8'(k * 17);
    run_packet(0, lat);
    a5b = rxb(0, 3);
    chk("a5_b0", {31'd0, a5b[0]}, 32'd1);
    chk("a5_b1", {31'd0, a5b[1]}, 32'd0);
    chk("a5_b2", {31'd0, a5b[2]}, 32'd1);
    chk("a5_b3", {31'd0, a5b[3]}, 32'd0);
    chk("a5_b4", {31'd0, a5b[4]}, 32'd0);
    chk("a5_b5", {31'd0, a5b[5]}, 32'd1);
    chk("a5_b6", {31'd0, a5b[6]}, 32'd0);
    chk("a5_b7", {31'd0, a5b[7]}, 32'd1);
    chk_frame_model(0, "a5");

    // 5: second request and payload change while busy
    for (int k = 0; k < PL0; k++) pb[0][k] = 8'h11;
    rxq0.delete();
    ndone0 = 0;
    @(negedge clk_50M_o); req[0] = 1'b1;
    @(negedge clk_50M_o); req[0] = 1'b0;
    repeat (1998) @(negedge clk_50M_o);
    req[0] = 1'b1;
    for (int k = 0; k < PL0; k++) pb[0][k] = 8'hFF;
    @(negedge clk_50M_o); req[0] = 1'b0;
    repeat (3000) @(negedge clk_50M_o);
    chk("busyreq_done_cnt", ndone0, 1);
    chk("busyreq_idle", {31'd0, busy[0]}, 32'd0);
    chk("busyreq_len", rxn(0), 15);
    for (int k = 3; k < 14; k++) chk($sformatf("busyreq_b%0d", k), {24'd0, rxb(0, k)}, 32'h11);
    chk_frame_model(0, "busyreq");

    // 6: reset in the middle of the payload
    for (int k = 0; k < PL0; k++) pb[0][k] = 8'h00;
    ndone0 = 0;
    @(negedge clk_50M_o); req[0] = 1'b1;
    @(negedge clk_50M_o); req[0] = 1'b0;
    repeat (837) @(negedge clk_50M_o);   // inside a zero data bit of payload byte 2
    chk("pre_reset_txd", {31'd0, txd[0]}, 32'd0);
    #3 rst_n = 1'b0;
    #1 chk("async_reset_txd", {31'd0, txd[0]}, 32'd1);
    chk("async_reset_busy", {31'd0, busy[0]}, 32'd0);
    repeat (5) @(negedge clk_50M_o);
    rst_n = 1'b1;
    repeat (400) @(negedge clk_50M_o);
    chk("reset_no_done", ndone0, 0);
    for (int k = 0; k < PL0; k++) pb[0][k] = 8'(k * 29 + 3);
    run_packet(0, lat);
    chk("after_reset_latency", lat, 1 + 15 * 10 * B);
    chk("after_reset_done_cnt", ndone0, 1);
    chk_frame_model(0, "after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
